// File: rtl/bcd_digit_entry_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_entry_pkg
//  Description : Shared constants for the keyed BCD entry path: digit limit,
//                bus widths, entry FSM state encodings and a digit check.
//  Revision    : 1.0  initial release
// ============================================================================
package bcd_digit_entry_pkg;

  localparam int BCD_W = 4;  // one BCD digit
  localparam int BIN_W = 6;  // binary result, up to 63
  localparam int SUM_W = 7;  // tens*10+ones, up to 99

  localparam logic [BCD_W-1:0] BCD_MAX_DIGIT = 4'd9;

  // Entry FSM encodings (plain constants so older tools can consume them).
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_ONES = 2'd1;
  localparam logic [1:0] ST_CONVERT   = 2'd2;

  function automatic logic is_bcd(input logic [BCD_W-1:0] d);
    return (d <= BCD_MAX_DIGIT);
  endfunction

endpackage : bcd_digit_entry_pkg
`default_nettype wire

// File: rtl/bcd_digit_entry_if.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_entry_if
//  Description : Keypad-side bus of the BCD entry block.
//                master : keypad decoder / controller (drives digits, clear)
//                slave  : bcd_digit_entry (drives result, status, echo)
//  Signals     : digit_in[3:0], digit_valid, clear        master -> slave
//                bin_out[5:0], bin_valid, err, busy,
//                tens_disp[3:0], ones_disp[3:0]           slave  -> master
//  Revision    : 1.0  initial release
// ============================================================================
interface bcd_digit_entry_if;
  import bcd_digit_entry_pkg::*;

  logic [BCD_W-1:0] digit_in;
  logic             digit_valid;
  logic             clear;
  logic [BIN_W-1:0] bin_out;
  logic             bin_valid;
  logic             err;
  logic             busy;
  logic [BCD_W-1:0] tens_disp;
  logic [BCD_W-1:0] ones_disp;

  modport master (
    output digit_in, digit_valid, clear,
    input  bin_out, bin_valid, err, busy, tens_disp, ones_disp
  );

  modport slave (
    input  digit_in, digit_valid, clear,
    output bin_out, bin_valid, err, busy, tens_disp, ones_disp
  );

endinterface : bcd_digit_entry_if
`default_nettype wire

// File: rtl/bcd_digit_entry_bcd_to_bin.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_to_bin
//  Description : Combinational two-digit BCD to binary: sum = tens*10 + ones.
//                Counterpart of the display-side binary-to-BCD table.
//  Ports       : tens[3:0], ones[3:0] in ; sum[6:0] out (0..99 for BCD input)
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_to_bin
  import bcd_digit_entry_pkg::*;
(
  input  logic [BCD_W-1:0] tens,
  input  logic [BCD_W-1:0] ones,
  output logic [SUM_W-1:0] sum
);

  // tens*10 as (tens<<3)+(tens<<1), all terms pre-extended to 7 bits.
  assign sum = {tens, 3'b000} + {2'b00, tens, 1'b0} + {3'b000, ones};

endmodule : bcd_to_bin
`default_nettype wire

// File: rtl/bcd_digit_entry.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_entry
//  Description : Collects a tens digit then a ones digit from the keypad,
//                converts to binary and range-checks against MAX_VAL.
//                Echoes partial input for the display.
//  Parameters  : MAX_VAL      largest accepted result (<= 63)
//                TIMEOUT_CYC  cycles allowed between tens and ones digit
//  Ports       : clk          rising-edge clock
//                rst_n        asynchronous active-low reset
//                bus          bcd_digit_entry_if.slave (digits in, result,
//                             bin_valid/err pulses, busy, display echo out)
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_digit_entry
  import bcd_digit_entry_pkg::*;
#(
  parameter int MAX_VAL     = 59,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bcd_digit_entry_if.slave     bus
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [SUM_W-1:0]  MAX_SUM  = SUM_W'(MAX_VAL);

  logic [1:0]       state_q,     state_d;
  logic [BCD_W-1:0] tens_q,      tens_d;
  logic [BCD_W-1:0] ones_q,      ones_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [BIN_W-1:0] bin_q,       bin_d;
  logic             bin_valid_q, bin_valid_d;
  logic             err_q,       err_d;
  logic             busy_q,      busy_d;

  logic [SUM_W-1:0] sum;

  bcd_to_bin u_bcd_to_bin (
    .tens (tens_q),
    .ones (ones_q),
    .sum  (sum)
  );

  always_comb begin
    state_d     = state_q;
    tens_d      = tens_q;
    ones_d      = ones_q;
    cnt_d       = cnt_q;
    bin_d       = bin_q;
    bin_valid_d = 1'b0;
    err_d       = 1'b0;

    if (bus.clear) begin
      // Abort wins over a strobe and over a pending conversion, silently.
      state_d = ST_IDLE;
      tens_d  = '0;
      ones_d  = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.digit_valid) begin
            if (is_bcd(bus.digit_in)) begin
              tens_d  = bus.digit_in;
              cnt_d   = '0;
              state_d = ST_WAIT_ONES;
            end else begin
              err_d = 1'b1;
            end
          end
        end

        ST_WAIT_ONES: begin
          // A strobe is examined before the timeout so a digit arriving on
          // the last allowed cycle is still taken.
          if (bus.digit_valid) begin
            if (is_bcd(bus.digit_in)) begin
              ones_d  = bus.digit_in;
              state_d = ST_CONVERT;
            end else begin
              err_d   = 1'b1;
              tens_d  = '0;
              ones_d  = '0;
              cnt_d   = '0;
              state_d = ST_IDLE;
            end
          end else if (cnt_q == CNT_LAST) begin
            err_d   = 1'b1;
            tens_d  = '0;
            ones_d  = '0;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_CONVERT: begin
          if (sum <= MAX_SUM) begin
            bin_d       = sum[BIN_W-1:0];
            bin_valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          tens_d  = '0;
          ones_d  = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end

        default: begin
          tens_d  = '0;
          ones_d  = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tens_q      <= '0;
      ones_q      <= '0;
      cnt_q       <= '0;
      bin_q       <= '0;
      bin_valid_q <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tens_q      <= tens_d;
      ones_q      <= ones_d;
      cnt_q       <= cnt_d;
      bin_q       <= bin_d;
      bin_valid_q <= bin_valid_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.bin_out   = bin_q;
  assign bus.bin_valid = bin_valid_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;
  assign bus.tens_disp = tens_q;
  assign bus.ones_disp = ones_q;

endmodule : bcd_digit_entry
`default_nettype wire

// File: tb/tb_bcd_digit_entry.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_digit_entry
//  Description : Self-checking bench for bcd_digit_entry. Expected result
//                pulses are queued when keys are driven and matched against
//                bin_valid/err pulses as the DUT emits them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bcd_digit_entry;

  localparam int MAX_VAL = 59;
  localparam int TO      = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_digit_entry_if bus ();

  bcd_digit_entry #(
    .MAX_VAL     (MAX_VAL),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       is_err;
    logic [5:0] val;     // bin_out expected while the pulse is high
    int         cyc;     // posedge count at which the pulse is visible
  } exp_t;

  exp_t       exp_q[$];
  int         cyc       = 0;
  int         checks    = 0;
  int         errors    = 0;
  logic [5:0] model_bin = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic expect_pulse(input logic is_err, input logic [5:0] val,
                              input int at);
    exp_t e;
    e.is_err = is_err;
    e.val    = val;
    e.cyc    = at;
    exp_q.push_back(e);
  endtask

  // Strobe one digit; it is sampled at the edge after the first wait.
  task automatic drive_key(input logic [3:0] d, input logic push,
                           input logic is_err, input logic [5:0] val,
                           input int lat);
    @(posedge clk); #1;
    if (push) expect_pulse(is_err, val, cyc + 1 + lat);
    bus.digit_in    = d;
    bus.digit_valid = 1'b1;
    @(posedge clk); #1;
    bus.digit_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Full two-digit entry with the result predicted from the digits.
  task automatic entry(input logic [3:0] t, input logic [3:0] o, input int gap);
    int s;
    drive_key(t, 1'b0, 1'b0, '0, 0);
    if (gap > 0) idle(gap);
    if (o > 4'd9) begin
      drive_key(o, 1'b1, 1'b1, model_bin, 0);
    end else begin
      s = t * 10 + o;
      if (s <= MAX_VAL) begin
        model_bin = 6'(s);
        drive_key(o, 1'b1, 1'b0, model_bin, 1);
      end else begin
        drive_key(o, 1'b1, 1'b1, model_bin, 1);
      end
    end
    idle(2);
  endtask

  // Scoreboard side: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.bin_valid || bus.err) begin
      check_eq("pulse_exclusive", {31'b0, bus.bin_valid & bus.err}, 32'd0);
      check_eq("pulse_expected", {31'b0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("pulse_kind", {31'b0, bus.err}, {31'b0, e.is_err});
        check_eq("pulse_bin_out", {26'b0, bus.bin_out}, {26'b0, e.val});
        check_eq("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired, queue=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.digit_in    = '0;
    bus.digit_valid = 1'b0;
    bus.clear       = 1'b0;

    // Reset state
    idle(3);
    check_eq("rst_bin_out", {26'b0, bus.bin_out}, 32'd0);
    check_eq("rst_busy", {31'b0, bus.busy}, 32'd0);
    check_eq("rst_tens", {28'b0, bus.tens_disp}, 32'd0);
    check_eq("rst_ones", {28'b0, bus.ones_disp}, 32'd0);
    check_eq("rst_pulses", {30'b0, bus.bin_valid, bus.err}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // 1: keys 4,2 with a 5-cycle gap
    drive_key(4'd4, 1'b0, 1'b0, '0, 0);
    check_eq("t1_busy_tens", {31'b0, bus.busy}, 32'd1);
    check_eq("t1_tens_disp", {28'b0, bus.tens_disp}, 32'd4);
    idle(5);
    model_bin = 6'd42;
    drive_key(4'd2, 1'b1, 1'b0, 6'd42, 1);
    check_eq("t1_ones_disp", {28'b0, bus.ones_disp}, 32'd2);
    check_eq("t1_busy_conv", {31'b0, bus.busy}, 32'd1);
    idle(1);
    check_eq("t1_bin_valid", {31'b0, bus.bin_valid}, 32'd1);
    check_eq("t1_busy_fall", {31'b0, bus.busy}, 32'd0);
    check_eq("t1_tens_clr", {28'b0, bus.tens_disp}, 32'd0);
    idle(1);
    check_eq("t1_bv_one_cycle", {31'b0, bus.bin_valid}, 32'd0);
    check_eq("t1_bin_hold", {26'b0, bus.bin_out}, 32'd42);

    // 2: range limit
    entry(4'd6, 4'd0, 1);
    check_eq("t2_bin_keep", {26'b0, bus.bin_out}, 32'd42);
    entry(4'd5, 4'd9, 0);
    check_eq("t2_bin_59", {26'b0, bus.bin_out}, 32'd59);

    // 3: non-BCD digits
    drive_key(4'hA, 1'b1, 1'b1, model_bin, 0);
    check_eq("t3_err_idle", {31'b0, bus.err}, 32'd1);
    check_eq("t3_busy_idle", {31'b0, bus.busy}, 32'd0);
    drive_key(4'd3, 1'b0, 1'b0, '0, 0);
    check_eq("t3_tens3", {28'b0, bus.tens_disp}, 32'd3);
    drive_key(4'hC, 1'b1, 1'b1, model_bin, 0);
    check_eq("t3_tens_clr", {28'b0, bus.tens_disp}, 32'd0);
    check_eq("t3_busy_clr", {31'b0, bus.busy}, 32'd0);
    idle(2);

    // 4: timeout, then a strobe on the last allowed cycle
    drive_key(4'd1, 1'b0, 1'b0, '0, 0);
    n = cyc;
    expect_pulse(1'b1, model_bin, n + TO);
    idle(TO + 2);
    check_eq("t4_to_busy", {31'b0, bus.busy}, 32'd0);
    check_eq("t4_to_tens", {28'b0, bus.tens_disp}, 32'd0);
    drive_key(4'd1, 1'b0, 1'b0, '0, 0);
    idle(TO - 2);
    model_bin = 6'd17;
    drive_key(4'd7, 1'b1, 1'b0, 6'd17, 1);
    idle(2);
    check_eq("t4_strobe_wins", {26'b0, bus.bin_out}, 32'd17);

    // 5: clear beats a strobe, and beats a pending conversion
    drive_key(4'd2, 1'b0, 1'b0, '0, 0);
    @(posedge clk); #1;
    bus.digit_in = 4'd5; bus.digit_valid = 1'b1; bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.digit_valid = 1'b0; bus.clear = 1'b0;
    check_eq("t5_clr_busy", {31'b0, bus.busy}, 32'd0);
    check_eq("t5_clr_disp", {24'b0, bus.tens_disp, bus.ones_disp}, 32'd0);
    drive_key(4'd3, 1'b0, 1'b0, '0, 0);
    drive_key(4'd4, 1'b0, 1'b0, '0, 0);
    bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    check_eq("t5_conv_no_bv", {31'b0, bus.bin_valid}, 32'd0);
    check_eq("t5_conv_busy", {31'b0, bus.busy}, 32'd0);
    idle(2);
    check_eq("t5_bin_keep", {26'b0, bus.bin_out}, 32'd17);

    // 6: asynchronous reset during WAIT_ONES
    drive_key(4'd5, 1'b0, 1'b0, '0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("t6_busy", {31'b0, bus.busy}, 32'd0);
    check_eq("t6_tens", {28'b0, bus.tens_disp}, 32'd0);
    check_eq("t6_bin_out", {26'b0, bus.bin_out}, 32'd0);
    model_bin = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    entry(4'd2, 4'd3, 2);
    check_eq("t6_after_rst", {26'b0, bus.bin_out}, 32'd23);

    idle(4);
    check_eq("sb_drain", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_bcd_digit_entry
`default_nettype wire
